// File: rtl/acumulador_mac.sv
// acumulador_mac: saturating signed fixed-point multiply-accumulate stage.
// Sums a frame of Terminos products (Q Magnitud.Decimal, sign included) with
// symmetric clamping, then presents the sum for one cycle with a listo pulse
// and a sticky overflow flag for that frame.
module acumulador_mac #(
   parameter int Decimal  = 16,
   parameter int Magnitud = 8,
   parameter int N        = Decimal + Magnitud + 1,
   parameter int Terminos = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inicio,
   input  logic         dato_valido,
   input  logic [N-1:0] dato,
   output logic         ocupado,
   output logic         listo,
   output logic [N-1:0] resultado,
   output logic         desborde
);

   localparam int CW = $clog2(Terminos + 1);

   localparam logic [1:0] REPOSO  = 2'd0;
   localparam logic [1:0] ACUMULA = 2'd1;
   localparam logic [1:0] ENTREGA = 2'd2;

   // Symmetric limits held one bit wider than the word so the raw sum compares directly.
   localparam logic signed [N:0] MAXIMO = {2'b00, {(N-1){1'b1}}};
   localparam logic signed [N:0] MINIMO = {2'b11, {(N-2){1'b0}}, 1'b1};
   // The most negative code has no positive mirror; it is folded onto MINIMO.
   localparam logic [N-1:0] CODIGO_PROHIBIDO = {1'b1, {(N-1){1'b0}}};

   logic [1:0]    estado_q, estado_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [CW-1:0] cuenta_q, cuenta_d;
   logic          flag_q, flag_d;
   logic [N-1:0]  resultado_q, resultado_d;
   logic          desborde_q, desborde_d;

   logic [N-1:0]        dato_ef;
   logic signed [N:0]   suma;
   logic [N-1:0]        suma_sat;
   logic                recorte;
   logic [CW-1:0]       cuenta_sig;

   // Saturating add of the running sum and the (sanitised) incoming product.
   always_comb begin
      dato_ef  = (dato == CODIGO_PROHIBIDO) ? MINIMO[N-1:0] : dato;
      suma     = $signed({acc_q[N-1], acc_q}) + $signed({dato_ef[N-1], dato_ef});
      suma_sat = suma[N-1:0];
      recorte  = 1'b0;
      if (suma > MAXIMO) begin
         suma_sat = MAXIMO[N-1:0];
         recorte  = 1'b1;
      end else if (suma < MINIMO) begin
         suma_sat = MINIMO[N-1:0];
         recorte  = 1'b1;
      end
      cuenta_sig = cuenta_q + CW'(1);
   end

   // Frame sequencing: idle, accept Terminos products, deliver for one cycle.
   always_comb begin
      estado_d    = estado_q;
      acc_d       = acc_q;
      cuenta_d    = cuenta_q;
      flag_d      = flag_q;
      resultado_d = resultado_q;
      desborde_d  = desborde_q;
      case (estado_q)
         REPOSO: begin
            if (inicio) begin
               acc_d    = '0;
               cuenta_d = '0;
               flag_d   = 1'b0;
               estado_d = ACUMULA;
            end
         end
         ACUMULA: begin
            if (dato_valido) begin
               acc_d    = suma_sat;
               cuenta_d = cuenta_sig;
               flag_d   = flag_q | recorte;
               if (cuenta_sig == CW'(Terminos)) begin
                  estado_d    = ENTREGA;
                  resultado_d = suma_sat;
                  desborde_d  = flag_q | recorte;
               end
            end
         end
         ENTREGA: begin
            estado_d = REPOSO;
         end
         default: begin
            estado_d = REPOSO;
         end
      endcase
   end

   // State registers; reset aborts any frame and clears the delivered result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q    <= REPOSO;
         acc_q       <= '0;
         cuenta_q    <= '0;
         flag_q      <= 1'b0;
         resultado_q <= '0;
         desborde_q  <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         acc_q       <= acc_d;
         cuenta_q    <= cuenta_d;
         flag_q      <= flag_d;
         resultado_q <= resultado_d;
         desborde_q  <= desborde_d;
      end
   end

   assign ocupado   = (estado_q != REPOSO);
   assign listo     = (estado_q == ENTREGA);
   assign resultado = resultado_q;
   assign desborde  = desborde_q;

endmodule

// File: tb/tb_acumulador_mac.sv
// Testbench for acumulador_mac (Terminos=4): directed frames with hand-computed
// sums; expectations are queued at issue time and checked by a monitor on listo.
module tb_acumulador_mac;

   localparam int N = 25;
   localparam int T = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         inicio = 1'b0;
   logic         dato_valido = 1'b0;
   logic [N-1:0] dato = '0;
   logic         ocupado;
   logic         listo;
   logic [N-1:0] resultado;
   logic         desborde;

   typedef struct {
      logic [N-1:0] res;
      logic         desb;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_listo = 1'b0;

   acumulador_mac #(
      .Decimal(16),
      .Magnitud(8),
      .N(N),
      .Terminos(T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .inicio(inicio),
      .dato_valido(dato_valido),
      .dato(dato),
      .ocupado(ocupado),
      .listo(listo),
      .resultado(resultado),
      .desborde(desborde)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame; gaps inserts i idle cycles before term i, hold keeps inicio high
   // through ACUMULA and the ENTREGA cycle.
   task automatic frame(input logic [N-1:0] d0, input logic [N-1:0] d1,
                        input logic [N-1:0] d2, input logic [N-1:0] d3,
                        input bit gaps, input bit hold,
                        input logic [N-1:0] er, input logic ed);
      logic [N-1:0] d[4];
      int   t0;
      exp_t e;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      inicio = 1'b1;
      t0 = cyc + 1;
      step();
      if (!hold) inicio = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            for (int g = 0; g < i; g++) begin
               dato_valido = 1'b0;
               dato = N'($urandom);
               step();
            end
         end
         dato_valido = 1'b1;
         dato = d[i];
         if (i == 3) begin
            e.res  = er;
            e.desb = ed;
            e.cyc  = gaps ? cyc + 1 : t0 + T;
            sb.push_back(e);
         end
         step();
      end
      dato_valido = 1'b0;
      dato = '0;
      step();
      chk("ocupado_drop", 32'(ocupado), 32'(0));
      inicio = 1'b0;
      $display("frame d=%h %h %h %h -> expected resultado=%h desborde=%0d", d0, d1, d2, d3, er, ed);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (listo) begin
               chk("listo_width", 32'(prev_listo), 32'(0));
               chk("ocupado_in_entrega", 32'(ocupado), 32'(1));
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_listo actual=listo resultado=%h required=no listo", resultado);
               end else begin
                  mon_e = sb.pop_front();
                  chk("resultado", 32'(resultado), 32'(mon_e.res));
                  chk("desborde", 32'(desborde), 32'(mon_e.desb));
                  chk("listo_cycle", 32'(cyc), 32'(mon_e.cyc));
               end
            end
            prev_listo = listo;
         end
      join_none

      // Reset held with inputs toggling: everything stays at zero.
      for (int i = 0; i < 6; i++) begin
         inicio      = 1'($urandom);
         dato_valido = 1'($urandom);
         dato        = N'($urandom);
         @(negedge clk);
         chk("reset_ctrl", 32'({ocupado, listo, desborde}), 32'(0));
         chk("reset_resultado", 32'(resultado), 32'(0));
      end
      @(posedge clk);
      #1;
      inicio = 1'b0;
      dato_valido = 1'b0;
      dato = '0;
      reset = 1'b1;
      step();
      chk("idle_after_reset", 32'(ocupado), 32'(0));

      frame(25'h0010000, 25'h0010000, 25'h0010000, 25'h0010000, 1'b0, 1'b0, 25'h0040000, 1'b0);
      frame(25'h0028000, 25'h1FEC000, 25'h0008000, 25'h1FF4000, 1'b1, 1'b0, 25'h0010000, 1'b0);
      frame(25'h0FF0000, 25'h0FF0000, 25'h0FF0000, 25'h0FF0000, 1'b0, 1'b0, 25'h0FFFFFF, 1'b1);
      frame(25'h0010000, 25'h0010000, 25'h0010000, 25'h0010000, 1'b0, 1'b0, 25'h0040000, 1'b0);
      frame(25'h1380000, 25'h1380000, 25'h0000000, 25'h0000000, 1'b0, 1'b0, 25'h1000001, 1'b1);
      frame(25'h1000000, 25'h0FFFFFF, 25'h0000000, 25'h0000000, 1'b0, 1'b0, 25'h0000000, 1'b0);
      frame(25'h0008000, 25'h0010000, 25'h0018000, 25'h0020000, 1'b1, 1'b1, 25'h0050000, 1'b0);

      // Abort after two of four terms with an asynchronous reset.
      inicio = 1'b1;
      step();
      inicio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         dato_valido = 1'b1;
         dato = 25'h0010000;
         step();
      end
      dato_valido = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("abort_ocupado", 32'(ocupado), 32'(0));
      chk("abort_resultado", 32'(resultado), 32'(0));
      $display("abort after 2 terms -> expected ocupado=0 resultado=0, no listo");
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("abort_no_pending", 32'(sb.size()), 32'(0));

      frame(25'h0010000, 25'h0010000, 25'h0010000, 25'h0010000, 1'b0, 1'b0, 25'h0040000, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
